iob_uart_lite_resp: RTL and testbench
=====================================

// Module: iob_uart_lite_resp
// PURPOSE
//  Native-interface (valid/addr/wdata/wstrb -> rdata/ready) responder for a testbench-drivable UART.
//  Decodes the tester-UART register accesses that the initiator issues and drives a serial 8N1 link.
//  Contains one TX shifter and one RX sampler with a one-byte holding register.
//  Sits on the tester side of the simulation top, opposite the initiator that issues register accesses.
// PARAMETERS
//  ADDR_W   3   word-address width of the register map
//  DATA_W   32  native data width; wstrb is DATA_W/8 bits
//  DIV_RST  16  reset value of DIV, in clocks per bit
// PORTS
//  clk     in   1         clock
//  rst     in   1         reset, synchronous, active-high
//  valid   in   1         request strobe; initiator holds it until ready
//  addr    in   ADDR_W    register word address
//  wdata   in   DATA_W    write data
//  wstrb   in   DATA_W/8  byte enables; 0 = read
//  rdata   out  DATA_W    read data, valid while ready=1
//  ready   out  1         one-cycle response pulse
//  txd     out  1         serial out, idle high
//  rxd     in   1         serial in, asynchronous
// BEHAVIOUR
//  Reset values: ready=0, rdata=0, txd=1, DIV=DIV_RST, TXEN=RXEN=0, both FSMs IDLE, RXREADY=0, OVR=0.
//  Handshake:
//   - Accept when valid&&!ready; ready=1 the next cycle for exactly one cycle, with rdata registered.
//   - valid seen while ready=1 is not a new request.
//   - Every access completes in 1 cycle; no wait states.
//  Register map (word address):
//   0 SOFTRESET  W    wdata[0]=1 -> FSMs IDLE, txd=1, RXREADY/OVR cleared; DIV/TXEN/RXEN unchanged
//   1 DIV        R/W  16b, lanes wstrb[1:0] applied independently; effective period = max(DIV,2)
//   2 TXDATA     W    wdata[7:0]; loaded only if TXEN && tx IDLE, otherwise silently dropped
//   3 TXEN       W    wdata[0]
//   4 TXREADY    R    bit0 = TXEN && tx IDLE
//   5 RXDATA     R    [7:0] = holding byte; the read clears RXREADY and OVR
//   6 RXEN       W    wdata[0]; 0 aborts an RX frame in progress
//   7 RXREADY    R    bit0 = holding full, bit1 = OVR (sticky)
//   - Byte-lane registers need wstrb[0]; writes without it are ignored.
//   - Writes to R-only addresses are ignored; reads of W-only addresses return 0.
//   - Unused rdata bits are 0.
//  TX FSM IDLE->START->DATA->STOP->IDLE:
//   - Each state lasts one bit period; data is sent LSB first.
//   - DIV is latched on entry to START.
//   - txd falls on the cycle ready is high for the TXDATA write.
//   - TXREADY reads 1 again from the cycle after the stop bit ends (10 bit periods total).
//  RX path:
//   - rxd passes a 2-flop synchroniser.
//   - Falling edge in IDLE (RXEN=1) -> START; recheck low at half period, else back to IDLE.
//   - DATA samples 8 bits at bit centres.
//   - STOP sample 1 -> byte to holding register, RXREADY=1.
//   - STOP sample 0 -> framing error: byte dropped, wait for rxd high, then IDLE.
//  Boundary cases:
//   - Byte completes while RXREADY=1: new byte discarded, OVR=1.
//   - RXDATA read in the same cycle a byte completes: the read returns the old byte; the new byte loads;
//     RXREADY stays 1; OVR is not set.
//   - DIV written mid-frame takes effect at the next frame.
//   - rst or SOFTRESET mid-frame: txd=1 from the next cycle; any partial byte is lost.
// STRUCTURE
//  iob_uart_lite_swreg.vh:
//   - register address localparams (0..7)
//   - TX/RX state encodings
//   - bit-count width of 3 and DIV width of 16
//  Sub-module iob_uart_lite_rx:
//   - synchroniser, RX FSM, holding register, OVR
//   - interface: clk, rst, soft_rst, en, div, rxd, rd_clr -> data, full, ovr
//  The top level keeps register decode, response logic and the TX FSM.
// TESTING
//  1 After rst: txd=1, ready=0; read addr1 -> rdata=16, ready exactly 1 cycle after valid.
//  2 DIV=8, TXEN=1, TXDATA=0x55 -> on txd: 8 clk low, then 1,0,1,0,1,0,1,0 (8 clk each), then 8 clk high;
//    TXREADY=0 throughout, 1 after 80 clk.
//  3 TXDATA=0xAA written at clk 20 of test 2 -> dropped; line carries 0x55 only.
//  4 RXEN=1, drive 0xA3 8N1 at 8 clk/bit -> RXREADY=0x1; RXDATA=0xA3; RXREADY then reads 0.
//  5 Drive 0x11 then 0x22, no read -> RXREADY=0x3, RXDATA=0x11, then RXREADY=0x0.
//  6 Framing and soft-reset cases:
//   - frame with stop bit 0 -> RXREADY stays 0
//   - SOFTRESET at clk 30 of a TX frame -> txd=1 next cycle, TXREADY=1

Source files
------------

// File: rtl/iob_uart_lite_resp_pkg.sv
// Shared register map, FSM encodings and widths for the tester-side UART responder.
// Pure declarations: no latency, no flow control.
package iob_uart_lite_resp_pkg;

  localparam int unsigned ADR_SOFTRESET = 0;
  localparam int unsigned ADR_DIV       = 1;
  localparam int unsigned ADR_TXDATA    = 2;
  localparam int unsigned ADR_TXEN      = 3;
  localparam int unsigned ADR_TXREADY   = 4;
  localparam int unsigned ADR_RXDATA    = 5;
  localparam int unsigned ADR_RXEN      = 6;
  localparam int unsigned ADR_RXREADY   = 7;

  localparam int BCNT_W = 3;
  localparam int DIV_W  = 16;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_e;

  // A bit period below two clocks leaves no room for a half-period centre sample.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(2)) ? DIV_W'(2) : d;
  endfunction

endpackage

// File: rtl/iob_uart_lite_rx.sv
// 8N1 receiver: 2-flop synchroniser, centre-sampling FSM, one-byte holding register with sticky overrun.
// Byte visible in data/full the cycle after its stop-bit sample; no backpressure, overflow sets ovr.
module iob_uart_lite_rx
  import iob_uart_lite_resp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             rxd,
  input  logic             rd_clr,
  output logic [7:0]       data,
  output logic             full,
  output logic             ovr
);

  logic [1:0]        sync_q, sync_d;
  logic              prev_q, prev_d;
  rx_state_e         state_q, state_d;
  logic [DIV_W-1:0]  rdiv_q, rdiv_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [BCNT_W-1:0] bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        data_q, data_d;
  logic              full_q, full_d;
  logic              ovr_q, ovr_d;

  logic             cur;
  logic             complete;
  logic [DIV_W-1:0] period;
  logic [DIV_W-1:0] half;
  logic             bit_end;
  logic             half_end;

  always_comb begin
    sync_d   = {sync_q[0], rxd};
    cur      = sync_q[1];
    prev_d   = cur;
    state_d  = state_q;
    rdiv_d   = rdiv_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    full_d   = full_q;
    ovr_d    = ovr_q;
    complete = 1'b0;
    period   = eff_div(rdiv_q);
    half     = period >> 1;
    bit_end  = (cnt_q == period - DIV_W'(1));
    half_end = (cnt_q == half - DIV_W'(1));

    case (state_q)
      RX_IDLE: begin
        if (en && prev_q && !cur) begin
          state_d = RX_START;
          rdiv_d  = div;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      RX_START: begin
        if (half_end) begin
          cnt_d   = '0;
          state_d = cur ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      RX_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {cur, shift_q[7:1]};
          if (bit_q == BCNT_W'(7)) state_d = RX_STOP;
          else                      bit_d   = bit_q + BCNT_W'(1);
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      RX_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (cur) begin
            complete = 1'b1;
            state_d  = RX_IDLE;
          end else begin
            state_d = RX_WAIT;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      RX_WAIT: begin
        if (cur) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase

    if (!en || soft_rst) begin
      state_d  = RX_IDLE;
      cnt_d    = '0;
      complete = 1'b0;
    end

    // A read landing on the completion cycle returns the old byte and frees the slot for the new one.
    if (complete) begin
      if (full_q && !rd_clr) begin
        ovr_d = 1'b1;
      end else begin
        data_d = shift_q;
        full_d = 1'b1;
        if (rd_clr) ovr_d = 1'b0;
      end
    end else if (rd_clr) begin
      full_d = 1'b0;
      ovr_d  = 1'b0;
    end

    if (soft_rst) begin
      full_d = 1'b0;
      ovr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      rdiv_q  <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      full_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      rdiv_q  <= rdiv_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      full_q  <= full_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data = data_q;
  assign full = full_q;
  assign ovr  = ovr_q;

endmodule

// File: rtl/iob_uart_lite_resp.sv
// Native-bus register responder driving an 8N1 UART: decode, single-cycle response, TX shifter.
// Every access answered with a one-cycle ready pulse the cycle after acceptance; never stalls.
module iob_uart_lite_resp
  import iob_uart_lite_resp_pkg::*;
#(
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 32,
  parameter int DIV_RST = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                txd,
  input  logic                rxd
);

  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              txd_q, txd_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              txen_q, txen_d;
  logic              rxen_q, rxen_d;
  tx_state_e         tx_state_q, tx_state_d;
  logic [DIV_W-1:0]  tx_div_q, tx_div_d;
  logic [DIV_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [BCNT_W-1:0] tx_bit_q, tx_bit_d;
  logic [7:0]        tx_shift_q, tx_shift_d;

  logic [31:0]       a32;
  logic              accept, is_wr, is_rd;
  logic              soft_rst, tx_ready, tx_load, rd_clr;
  logic              tx_bit_end;
  logic [DATA_W-1:0] rd_val;
  logic [7:0]        rx_data;
  logic              rx_full, rx_ovr;
  logic              unused_wdata;

  assign unused_wdata = ^wdata[DATA_W-1:16];

  always_comb begin
    a32      = 32'(addr);
    accept   = valid && !ready_q;
    is_wr    = accept && (wstrb != '0);
    is_rd    = accept && (wstrb == '0);
    soft_rst = is_wr && (a32 == ADR_SOFTRESET) && wstrb[0] && wdata[0];
    tx_ready = txen_q && (tx_state_q == TX_IDLE);
    tx_load  = is_wr && (a32 == ADR_TXDATA) && wstrb[0] && tx_ready;
    rd_clr   = is_rd && (a32 == ADR_RXDATA);

    div_d  = div_q;
    txen_d = txen_q;
    rxen_d = rxen_q;
    if (is_wr && (a32 == ADR_DIV)) begin
      if (wstrb[0]) div_d[7:0]  = wdata[7:0];
      if (wstrb[1]) div_d[15:8] = wdata[15:8];
    end
    if (is_wr && (a32 == ADR_TXEN) && wstrb[0]) txen_d = wdata[0];
    if (is_wr && (a32 == ADR_RXEN) && wstrb[0]) rxen_d = wdata[0];

    rd_val = '0;
    case (a32)
      ADR_DIV:     rd_val[15:0] = div_q;
      ADR_TXREADY: rd_val[0]    = tx_ready;
      ADR_RXDATA:  rd_val[7:0]  = rx_data;
      ADR_RXREADY: rd_val[1:0]  = {rx_ovr, rx_full};
      default:     rd_val       = '0;
    endcase

    ready_d = accept;
    rdata_d = is_rd ? rd_val : '0;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_div_d   = tx_div_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_bit_end = (tx_cnt_q == eff_div(tx_div_q) - DIV_W'(1));

    case (tx_state_q)
      TX_IDLE: begin
        if (tx_load) begin
          tx_state_d = TX_START;
          tx_div_d   = div_q;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_shift_d = wdata[7:0];
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + DIV_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == BCNT_W'(7)) tx_state_d = TX_STOP;
          else                         tx_bit_d   = tx_bit_q + BCNT_W'(1);
        end else begin
          tx_cnt_d = tx_cnt_q + DIV_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + DIV_W'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    if (soft_rst) begin
      tx_state_d = TX_IDLE;
      tx_cnt_d   = '0;
    end

    // Registered line driven from next state, so txd changes together with the state it reflects.
    case (tx_state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      txd_q      <= 1'b1;
      div_q      <= DIV_W'(DIV_RST);
      txen_q     <= 1'b0;
      rxen_q     <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_div_q   <= '0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      txd_q      <= txd_d;
      div_q      <= div_d;
      txen_q     <= txen_d;
      rxen_q     <= rxen_d;
      tx_state_q <= tx_state_d;
      tx_div_q   <= tx_div_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  iob_uart_lite_rx u_rx (
    .clk      (clk),
    .rst      (rst),
    .soft_rst (soft_rst),
    .en       (rxen_q),
    .div      (div_q),
    .rxd      (rxd),
    .rd_clr   (rd_clr),
    .data     (rx_data),
    .full     (rx_full),
    .ovr      (rx_ovr)
  );

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign txd   = txd_q;

endmodule

// File: tb/tb_iob_uart_lite_resp.sv
// Directed bench for iob_uart_lite_resp: register access, TX waveform, RX framing and boundary cases.
module tb_iob_uart_lite_resp;

  localparam int A_SOFT = 0, A_DIV = 1, A_TXDATA = 2, A_TXEN = 3;
  localparam int A_TXRDY = 4, A_RXDATA = 5, A_RXEN = 6, A_RXRDY = 7;
  localparam int BIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic        txd;
  logic        rxd;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_rdy = 0;
  logic txd_log [0:8191];

  iob_uart_lite_resp #(.ADDR_W(3), .DATA_W(32), .DIV_RST(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .valid (valid),
    .addr  (addr),
    .wdata (wdata),
    .wstrb (wstrb),
    .rdata (rdata),
    .ready (ready),
    .txd   (txd),
    .rxd   (rxd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) txd_log[cyc % 8192] <= txd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic bus(input int a, input logic [31:0] d, input logic [3:0] s, output logic [31:0] r);
    int n;
    n = 0;
    @(negedge clk);
    while (ready && n < 4) begin
      @(negedge clk);
      n++;
    end
    valid = 1'b1;
    addr  = 3'(a);
    wdata = d;
    wstrb = s;
    @(posedge clk);
    #1;
    chk("ready_pulse", {31'b0, ready}, 32'd1);
    r        = rdata;
    last_rdy = cyc;
    valid    = 1'b0;
    wstrb    = 4'h0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    logic [31:0] r;
    bus(a, d, 4'hF, r);
  endtask

  task automatic rd(input int a, output logic [31:0] r);
    bus(a, 32'h0, 4'h0, r);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (BIT) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
    rxd = stop;
    repeat (BIT) @(posedge clk);
    #1;
    rxd = 1'b1;
  endtask

  function automatic logic tx_exp(input logic [7:0] b, input int k);
    int p;
    p = k / BIT;
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
    return 1'b1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int t0, a, s0;
    bit wrote;

    rst = 1'b1; valid = 1'b0; addr = '0; wdata = '0; wstrb = '0; rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", {31'b0, txd}, 32'd1);
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 1'b0;

    // 1: reset DIV, single-cycle pulse
    rd(A_DIV, r);
    chk("div_rst", r, 32'd16);
    @(posedge clk);
    #1;
    chk("ready_drop", {31'b0, ready}, 32'd0);
    chk("idle_txrdy_rd", {31'b0, txd}, 32'd1);

    // DIV byte lanes, masked TXEN write, W-only read
    bus(A_DIV, 32'h0000_0300, 4'b0010, r);
    rd(A_DIV, r);
    chk("div_hi_lane", r, 32'h0310);
    bus(A_DIV, 32'h0000_0008, 4'b0001, r);
    bus(A_DIV, 32'h0000_0000, 4'b0010, r);
    rd(A_DIV, r);
    chk("div_8", r, 32'h0008);
    bus(A_TXEN, 32'h1, 4'b0010, r);
    rd(A_TXRDY, r);
    chk("txen_no_lane0", r, 32'd0);
    wr(A_TXEN, 32'h1);
    rd(A_TXRDY, r);
    chk("txready_en", r, 32'd1);
    rd(A_TXDATA, r);
    chk("wo_read_zero", r, 32'd0);

    // 2+3: 0x55 on the line, 0xAA written mid-frame is dropped
    wr(A_TXDATA, 32'h55);
    t0 = last_rdy;
    wrote = 1'b0;
    while (cyc < t0 + 86) begin
      if (!wrote && cyc >= t0 + 18) begin
        wr(A_TXDATA, 32'hAA);
        wrote = 1'b1;
      end else begin
        rd(A_TXRDY, r);
        a = last_rdy - 1;
        chk("txready_frame", r, (a >= t0 + 80) ? 32'd1 : 32'd0);
      end
    end
    for (int k = 0; k < 86; k++)
      chk("txd_55", {31'b0, txd_log[(t0 + k) % 8192]}, {31'b0, tx_exp(8'h55, k)});

    // 4: receive 0xA3
    wr(A_RXEN, 32'h1);
    send_byte(8'hA3, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rd(A_RXRDY, r);
    chk("rx_rdy_a3", r, 32'h1);
    rd(A_RXDATA, r);
    chk("rx_data_a3", r, 32'hA3);
    rd(A_RXRDY, r);
    chk("rx_rdy_clr", r, 32'h0);

    // 5: overrun
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rd(A_RXRDY, r);
    chk("rx_ovr", r, 32'h3);
    rd(A_RXDATA, r);
    chk("rx_ovr_data", r, 32'h11);
    rd(A_RXRDY, r);
    chk("rx_ovr_clr", r, 32'h0);

    // 6a: framing error dropped, next good frame received
    send_byte(8'h5A, 1'b0);
    repeat (16) @(posedge clk);
    #1;
    rd(A_RXRDY, r);
    chk("rx_frame_err", r, 32'h0);
    send_byte(8'h5A, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rd(A_RXRDY, r);
    chk("rx_after_ferr", r, 32'h1);
    rd(A_RXDATA, r);
    chk("rx_after_ferr_data", r, 32'h5A);

    // read on the exact completion cycle (stop sample lands 78 cycles after rxd falls)
    send_byte(8'h3C, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    s0 = cyc;
    fork
      send_byte(8'hC3, 1'b1);
      begin
        wait_cyc(s0 + 78);
        rd(A_RXDATA, r);
        chk("rx_same_cyc_old", r, 32'h3C);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    rd(A_RXRDY, r);
    chk("rx_same_cyc_rdy", r, 32'h1);
    rd(A_RXDATA, r);
    chk("rx_same_cyc_new", r, 32'hC3);

    // 6b: SOFTRESET mid TX frame
    wr(A_TXDATA, 32'h00);
    t0 = last_rdy;
    wait_cyc(t0 + 29);
    wr(A_SOFT, 32'h1);
    wait_cyc(t0 + 41);
    chk("txd_pre_soft", {31'b0, txd_log[(t0 + 29) % 8192]}, 32'd0);
    for (int k = 30; k < 40; k++)
      chk("txd_post_soft", {31'b0, txd_log[(t0 + k) % 8192]}, 32'd1);
    rd(A_TXRDY, r);
    chk("txready_soft", r, 32'd1);
    rd(A_DIV, r);
    chk("div_kept_soft", r, 32'h0008);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
